uart_rx_buffered: RTL and testbench
===================================

// Module: uart_rx_buffered
// PURPOSE
//  UART receiver for the far end of the existing uart_tx link: 8 data bits, LSB first, optional even/odd parity, 1 stop bit.
//  Samples each bit with a 3-sample majority vote, flags parity, framing and break errors, and queues received bytes
//  in a FIFO with a valid/ready pop interface. Sits between the pad-side rx line and the host/register bus.
// PARAMETERS
//  BIT_TIME      434  clocks per bit (50 MHz / 115200); 16-bit counter, legal 8..65535
//  SAMPLE_POINT  217  counter value of the centre sample; legal 1..BIT_TIME-3
//  FIFO_DEPTH    8    FIFO entries; power of two, >=2
//  FIFO_AW       3    log2(FIFO_DEPTH)
// PORTS
//  clk           in   1          system clock
//  reset         in   1          asynchronous, active-high reset
//  rx            in   1          serial line, idle high, asynchronous to clk
//  parity_en     in   1          1 = parity bit expected after bit 7
//  parity_odd    in   1          0 = even parity, 1 = odd parity
//  rx_ready      in   1          consumer accepts head entry this cycle
//  rx_valid      out  1          FIFO non-empty; head entry on rx_data/flags
//  rx_data       out  8          head entry data byte
//  rx_parity_err out  1          head entry parity error (0 when parity_en was 0)
//  rx_frame_err  out  1          head entry stop bit sampled low
//  overrun       out  1          1-cycle pulse: completed byte dropped, FIFO full
//  break_det     out  1          1-cycle pulse: break condition detected
//  fifo_count    out  FIFO_AW+1  number of entries held
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; FSM IDLE; sync flops to 1; armed=0; in-flight frame discarded.
//  Input: 2-flop synchroniser rx -> rx_s. armed is set by any cycle with rx_s=1, so reset mid-frame never false-starts.
//  Counter: 16-bit; cleared on each state entry; increments every cycle otherwise.
//  Majority: samples taken at counter SAMPLE_POINT-1, SAMPLE_POINT, SAMPLE_POINT+1; bit decided at SAMPLE_POINT+1 (2 of 3).
//  FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
//   IDLE: if armed and rx_s=0 -> START (that cycle is counter 0 of the start bit).
//   START: majority=1 -> IDLE (glitch rejected, no flag); at BIT_TIME-1 -> DATA, bit_cnt=0.
//   DATA: majority -> shift_reg[bit_cnt]; at BIT_TIME-1: bit_cnt==7 -> PARITY if parity_en else STOP; else bit_cnt+1.
//   PARITY: perr = majority != (parity_odd ? ~^shift_reg : ^shift_reg); at BIT_TIME-1 -> STOP.
//   STOP: on the majority decision: if stop=0, data==0 and (no parity or parity bit 0) -> break_det pulse, no push, BRK_WAIT;
//         otherwise push {ferr=~stop, perr, data} and -> IDLE the same cycle (half-bit early resync for back-to-back frames).
//   BRK_WAIT: stay until rx_s=1 -> IDLE.
//  parity_en/parity_odd are sampled per bit; changing them mid-frame is unsupported; result is undefined only for that frame.
//  FIFO: first-word-fall-through; rx_valid = count!=0; head fields combinational from mem[rd_ptr].
//   Pop = rx_valid & rx_ready. Push visible on rx_valid the cycle after the STOP decision (latency 1).
//   Push while full without pop: entry dropped, overrun pulses, contents unchanged.
//   Push and pop in the same cycle while full: both performed, no overrun, count unchanged.
//   Push and pop in the same cycle while empty is impossible (pop needs valid); push alone -> count 1.
//   Pointers wrap modulo FIFO_DEPTH; fifo_count = wr-rd using FIFO_AW+1-bit pointers.
// STRUCTURE
//  uart_pkg: state encodings, default BIT_TIME/SAMPLE_POINT, FIFO entry width (10 = ferr,perr,data[7:0]).
//  Sub-module uart_sync_fifo (width, depth params; push/pop/full/empty/count; FWFT) instantiated once.
//  FSM, synchroniser and majority logic live in this module.
// TESTING
//  Drive with uart_tx (parity off), send 0xA5 -> rx_valid, rx_data=0xA5, both error flags 0; rx_ready pops; count back to 0.
//  Even parity, 0x3C, corrupted parity bit -> rx_data=0x3C, rx_parity_err=1; odd parity, 0x01, correct bit -> err 0.
//  Stop bit forced low, data 0x55 -> rx_frame_err=1, no break_det; rx low 12 bit times -> break_det pulse, no push, IDLE after rx high.
//  1-clock low glitch mid-bit and 100-clock low pulse on idle line -> no push, FSM returns to IDLE; mid-bit glitch does not flip data.
//  rx_ready=0, 9 frames 0x00..0x08 (depth 8) -> count 8, overrun pulse once, head 0x00; drain yields 0x00..0x07 in order.
//  Assert reset during DATA bit 4 with rx held low -> all outputs 0, no frame received until rx returns high and a new start bit arrives.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the buffered UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BRK_WAIT
  } rx_state_t;

  localparam int DEF_BIT_TIME     = 434;
  localparam int DEF_SAMPLE_POINT = 217;
  localparam int ENTRY_W          = 10;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic expected_parity(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head is combinational from the read pointer.
module uart_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver (8 data bits, optional parity, 1 stop) with majority-vote sampling
// and a FWFT receive FIFO carrying per-byte parity/framing flags.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | line idle, waiting for a falling edge once armed
// S_START    | validating start bit; high majority rejects it as a glitch
// S_DATA     | sampling data bits 0..7, LSB first
// S_PARITY   | sampling parity bit and computing the parity error
// S_STOP     | sampling stop bit; push entry or detect break
// S_BRK_WAIT | break seen, waiting for the line to return high
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int BIT_TIME     = DEF_BIT_TIME,
  parameter int SAMPLE_POINT = DEF_SAMPLE_POINT,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_AW      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  input  logic               parity_en,
  input  logic               parity_odd,
  input  logic               rx_ready,
  output logic               rx_valid,
  output logic [7:0]         rx_data,
  output logic               rx_parity_err,
  output logic               rx_frame_err,
  output logic               overrun,
  output logic               break_det,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam logic [15:0] BIT_LAST = 16'(BIT_TIME - 1);
  localparam logic [15:0] SMP_A    = 16'(SAMPLE_POINT - 1);
  localparam logic [15:0] SMP_B    = 16'(SAMPLE_POINT);
  localparam logic [15:0] SMP_C    = 16'(SAMPLE_POINT + 1);

  logic        rx_meta;
  logic        rx_s;
  logic [1:0]  settle;
  logic        armed;

  rx_state_t   state;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        s0;
  logic        s1;
  logic        perr;
  logic        par_bit;

  logic        maj;
  logic        decide;
  logic        bit_end;
  logic        brk_cond;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  rx_entry_t   push_entry;
  rx_entry_t   head_entry;

  // Arming waits until the synchroniser holds a real post-reset sample, so a
  // reset released while rx is low cannot be mistaken for a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      settle  <= 2'd0;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      if (settle != 2'd2) settle <= settle + 2'd1;
      if (settle == 2'd2 && rx_s) armed <= 1'b1;
    end
  end

  assign maj      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign decide   = (cnt == SMP_C);
  assign bit_end  = (cnt == BIT_LAST);
  assign brk_cond = !maj && (shift_reg == 8'h00) && (!parity_en || !par_bit);
  assign push     = (state == S_STOP) && decide && !brk_cond;
  assign pop      = rx_valid && rx_ready;

  assign push_entry.ferr = !maj;
  assign push_entry.perr = perr;
  assign push_entry.data = shift_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      perr      <= 1'b0;
      par_bit   <= 1'b0;
      break_det <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      cnt       <= cnt + 16'd1;
      break_det <= 1'b0;
      overrun   <= push && fifo_full && !pop;
      if (cnt == SMP_A) s0 <= rx_s;
      if (cnt == SMP_B) s1 <= rx_s;

      case (state)
        S_IDLE: begin
          if (armed && !rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (decide && maj) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (bit_end) begin
            state   <= S_DATA;
            cnt     <= '0;
            bit_cnt <= '0;
            perr    <= 1'b0;
            par_bit <= 1'b0;
          end
        end
        S_DATA: begin
          if (decide) shift_reg[bit_cnt] <= maj;
          if (bit_end) begin
            cnt <= '0;
            if (bit_cnt == 3'd7) state <= parity_en ? S_PARITY : S_STOP;
            else bit_cnt <= bit_cnt + 3'd1;
          end
        end
        S_PARITY: begin
          if (decide) begin
            perr    <= (maj != expected_parity(shift_reg, parity_odd));
            par_bit <= maj;
          end
          if (bit_end) begin
            state <= S_STOP;
            cnt   <= '0;
          end
        end
        // Leaving at the stop-bit centre gives half a bit of slack to catch
        // the next start edge of back-to-back frames.
        S_STOP: begin
          if (decide) begin
            cnt <= '0;
            if (brk_cond) begin
              break_det <= 1'b1;
              state     <= S_BRK_WAIT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_BRK_WAIT: begin
          if (rx_s) begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rx_valid      = !fifo_empty;
  assign rx_data       = head_entry.data;
  assign rx_parity_err = head_entry.perr;
  assign rx_frame_err  = head_entry.ferr;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: frames, parity/framing errors, break,
// glitch rejection, FIFO overrun and drain, reset during a frame.
module tb_uart_rx_buffered;
  import uart_pkg::*;

  localparam int BT = 220;
  localparam int SP = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       rx_ready = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       overrun;
  logic       break_det;
  logic [3:0] fifo_count;

  int pass_cnt = 0;
  int total    = 0;
  int brk_seen = 0;
  int ov_seen  = 0;
  int brk0;
  int ov0;

  always #5 clk = ~clk;

  uart_rx_buffered #(
    .BIT_TIME     (BT),
    .SAMPLE_POINT (SP),
    .FIFO_DEPTH   (8),
    .FIFO_AW      (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx            (rx),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .rx_ready      (rx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .overrun       (overrun),
    .break_det     (break_det),
    .fifo_count    (fifo_count)
  );

  always @(posedge clk) begin
    if (break_det) brk_seen++;
    if (overrun) ov_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit period; optional 1-clock inversion landing on the centre sample.
  task automatic send_bit(input logic b, input logic glitch);
    rx = b;
    if (glitch) begin
      hold(SP + 1);
      rx = ~b;
      hold(1);
      rx = b;
      hold(BT - SP - 2);
    end else begin
      hold(BT);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic odd,
                            input logic flip_par, input logic stop, input int glitch_bit);
    logic p;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], i == glitch_bit);
    if (par) begin
      p = odd ? ~^d : ^d;
      send_bit(p ^ flip_par, 1'b0);
    end
    send_bit(stop, 1'b0);
    rx = 1'b1;
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    hold(3);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_count", fifo_count, 0);
    check("reset_flags", {rx_parity_err, rx_frame_err, overrun, break_det}, 0);
    reset = 1'b0;
    hold(2 * BT);

    // Plain frame, no parity
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    hold(4);
    check("a5_valid", rx_valid, 1);
    check("a5_data", rx_data, 8'hA5);
    check("a5_errs", {rx_parity_err, rx_frame_err}, 2'b00);
    check("a5_count", fifo_count, 1);
    pop_one();
    check("a5_pop_count", fifo_count, 0);
    check("a5_pop_valid", rx_valid, 0);

    // Even parity with a corrupted parity bit
    parity_en = 1'b1;
    parity_odd = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    hold(4);
    check("3c_data", rx_data, 8'h3C);
    check("3c_perr", rx_parity_err, 1);
    check("3c_ferr", rx_frame_err, 0);
    pop_one();

    // Odd parity, correct bit
    parity_odd = 1'b1;
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, -1);
    hold(4);
    check("01_data", rx_data, 8'h01);
    check("01_perr", rx_parity_err, 0);
    pop_one();
    parity_en = 1'b0;
    parity_odd = 1'b0;

    // Framing error, not a break
    brk0 = brk_seen;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    hold(2 * BT);
    check("55_data", rx_data, 8'h55);
    check("55_ferr", rx_frame_err, 1);
    check("55_perr", rx_parity_err, 0);
    check("55_count", fifo_count, 1);
    check("55_no_break", brk_seen - brk0, 0);
    pop_one();

    // Break: line low 12 bit times
    brk0 = brk_seen;
    rx = 1'b0;
    hold(12 * BT);
    check("brk_pulse", brk_seen - brk0, 1);
    check("brk_state", dut.state, S_BRK_WAIT);
    check("brk_no_push", fifo_count, 0);
    rx = 1'b1;
    hold(BT);
    check("brk_idle", dut.state, S_IDLE);

    // 100-clock low pulse on idle line
    rx = 1'b0;
    hold(100);
    rx = 1'b1;
    hold(2 * BT);
    check("pulse_no_push", fifo_count, 0);
    check("pulse_idle", dut.state, S_IDLE);

    // 1-clock glitch on the centre of data bit 3
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    hold(4);
    check("glitch_data", rx_data, 8'h5A);
    check("glitch_count", fifo_count, 1);
    pop_one();

    // Fill past depth without popping
    ov0 = ov_seen;
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b1, -1);
    hold(4);
    check("ovr_count", fifo_count, 8);
    check("ovr_pulse", ov_seen - ov0, 1);
    check("ovr_head", rx_data, 8'h00);
    for (int i = 0; i < 8; i++) begin
      check("drain_data", rx_data, 32'(i));
      pop_one();
    end
    check("drain_empty", fifo_count, 0);

    // Reset during data bit 4 with rx held low
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    hold(4);
    check("pre_rst_count", fifo_count, 1);
    rx = 1'b0;
    hold(5 * BT + BT / 2);
    check("pre_rst_state", dut.state, S_DATA);
    reset = 1'b1;
    hold(2);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_count", fifo_count, 0);
    reset = 1'b0;
    hold(3 * BT);
    check("rst_low_idle", dut.state, S_IDLE);
    check("rst_low_count", fifo_count, 0);
    rx = 1'b1;
    hold(BT);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    hold(4);
    check("post_rst_valid", rx_valid, 1);
    check("post_rst_data", rx_data, 8'hC3);
    check("post_rst_count", fifo_count, 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
